// File: rtl/photodiode_pkg.sv
// Shared constants for the photodiode array: register map,
// event word layout and control/status bit positions.
package photodiode_pkg;

  localparam logic [1:0] ADDR_STATE   = 2'd0;
  localparam logic [1:0] ADDR_EVENT   = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int VALID_BIT  = 31;
  localparam int EDGE_BIT   = 24;
  localparam int CH_LSB     = 20;
  localparam int CH_W       = 4;
  localparam int TS_W       = 20;

  localparam int EN_W       = 16;
  localparam int IRQ_EN_BIT = 31;
  localparam int OVF_BIT    = 16;
  localparam int FILL_W     = 9;

  function automatic logic [31:0] event_word(
    input logic            rise,
    input logic [CH_W-1:0] ch,
    input logic [TS_W-1:0] ts
  );
    logic [31:0] w;
    w = '0;
    w[VALID_BIT] = 1'b1;
    w[EDGE_BIT] = rise;
    w[CH_LSB +: CH_W] = ch;
    w[TS_W-1:0] = ts;
    return w;
  endfunction

endpackage

// File: rtl/photodiode_debounce.sv
// One photodiode channel: optional inversion, synchroniser chain
// and a stability counter that toggles the accepted level.
module photodiode_debounce
  import photodiode_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic flip
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];
  // flip is high in the cycle whose edge toggles stable
  assign flip = (synced != stable) &&
                (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw ^ INVERT};
      if (synced == stable) begin
        cnt <= '0;
      end else if (flip) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/photodiode_array.sv
// Multi-channel photodiode front end: debounced channels, timestamped
// beam events in a FIFO, Avalon-MM register access and a level irq.
module photodiode_array
  import photodiode_pkg::*;
#(
  parameter int NUM_CH          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 16,
  parameter logic [NUM_CH-1:0] INVERT = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_CH-1:0] photodiode_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] flip;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] svc;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] en_ch;
  logic [CH_W-1:0]   gidx;
  logic [EN_W-1:0]   enable;
  logic              irq_en;
  logic [TS_W-1:0]   ts;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              full;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;
  logic              wr_ctrl;
  logic              w1c_ovf;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign clk   = clk_clk;
  assign rst_n = reset_reset_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    photodiode_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT[i])
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (photodiode_in[i]),
      .stable (stable[i]),
      .flip   (flip[i])
    );
  end

  assign en_ch = enable[NUM_CH-1:0];
  assign svc   = pending & en_ch;

  // lowest index wins: the descending loop lets it overwrite last
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (svc[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gidx     = CH_W'(i);
      end
    end
  end

  assign push_req = |svc;
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = avs_read && (avs_address == ADDR_EVENT) &&
                    (count != '0);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign wr_ctrl  = avs_write && (avs_address == ADDR_CONTROL);
  assign w1c_ovf  = avs_write && (avs_address == ADDR_STATUS) &&
                    avs_writedata[OVF_BIT];
  assign unused_wdata = ^avs_writedata[30:17];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rise    <= '0;
      ts      <= '0;
    end else begin
      ts      <= ts + 1'b1;
      pending <= ((pending & ~grant) | flip) & en_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (flip[i]) rise[i] <= ~stable[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= event_word(|(grant & rise), gidx, ts);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (avs_address)
      ADDR_STATE: rdata[NUM_CH-1:0] = stable;
      ADDR_EVENT: if (count != '0) rdata = mem[rptr];
      ADDR_CONTROL: begin
        rdata[EN_W-1:0]   = enable;
        rdata[IRQ_EN_BIT] = irq_en;
      end
      ADDR_STATUS: begin
        rdata[CNT_W-1:0] = count;
        rdata[OVF_BIT]   = overflow;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_readdata <= '0;
      enable       <= '1;
      irq_en       <= 1'b0;
      overflow     <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= rdata;
      if (wr_ctrl) begin
        enable <= avs_writedata[EN_W-1:0];
        irq_en <= avs_writedata[IRQ_EN_BIT];
      end
      // a fresh drop beats a simultaneous clear
      if (drop)         overflow <= 1'b1;
      else if (w1c_ovf) overflow <= 1'b0;
      irq <= irq_en & ((count != '0) | overflow);
    end
  end

endmodule

// File: tb/tb_photodiode_array.sv
// Randomised bench for photodiode_array against a cycle-arithmetic
// event model with a queue-based FIFO scoreboard.
module tb_photodiode_array;
  import photodiode_pkg::*;

  localparam int NCH  = 8;
  localparam int SS   = 2;
  localparam int DC   = 12;
  localparam int FD   = 4;
  localparam int HOLD = SS + DC + NCH + 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] pin = '0;
  logic [1:0]     avs_address = '0;
  logic           avs_read = 1'b0;
  logic           avs_write = 1'b0;
  logic [31:0]    avs_writedata = '0;
  logic [31:0]    avs_readdata;
  logic           irq;

  photodiode_array #(
    .NUM_CH          (NCH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .FIFO_DEPTH      (FD),
    .INVERT          ('0)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .photodiode_in (pin),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  logic [NCH-1:0] st_m = '0;
  logic [15:0]    en_m = 16'hFFFF;
  logic           ien_m = 1'b0;
  logic           ovf_m = 1'b0;
  logic [31:0]    q[$];
  int             checks = 0;
  int             fails = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  function automatic logic [31:0] ev(input logic r, input int ch,
                                     input int t);
    return 32'h8000_0000 | (32'(r) << 24) | (32'(ch) << 20) |
           (32'(t) & 32'h000F_FFFF);
  endfunction

  task automatic apply_raw(input logic [NCH-1:0] v);
    int r = 0;
    int c0 = cyc;
    pin = v;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] != st_m[i] && en_m[i]) begin
        if (q.size() < FD) q.push_back(ev(v[i], i, c0 + SS + DC + r));
        else ovf_m = 1'b1;
        r++;
      end
    end
    st_m = v;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic glitch_raw(input logic [NCH-1:0] v, input int len);
    pin = v;
    repeat (len) @(negedge clk);
    pin = st_m;
    repeat (SS + 2) @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    logic [31:0] d;
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      e = (q.size() > 0) ? q.pop_front() : 32'h0;
      bus_read(ADDR_EVENT, d);
      check(tag, d, e);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    repeat (2) @(negedge clk);
    check({tag, ".irq"}, 32'(irq),
          32'(ien_m & ((q.size() != 0) | ovf_m)));
    bus_read(ADDR_STATE, d);
    check({tag, ".state"}, d, 32'(st_m));
    bus_read(ADDR_STATUS, d);
    check({tag, ".status"}, d, (32'(ovf_m) << 16) | 32'(q.size()));
    bus_read(ADDR_CONTROL, d);
    check({tag, ".control"}, d, (32'(ien_m) << 31) | 32'(en_m));
  endtask

  task automatic model_reset();
    st_m = '0;
    en_m = 16'hFFFF;
    ien_m = 1'b0;
    ovf_m = 1'b0;
    q.delete();
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] w;
    int tgt;
    int c0;

    repeat (3) @(negedge clk);
    check("rst.irq", 32'(irq), 32'h0);
    check("rst.rdata", avs_readdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_regs("reset");

    apply_raw(8'h08);
    check_regs("ch3");
    drain(2, "ch3.event");

    glitch_raw(8'h09, DC - 1);
    glitch_raw(8'h09, DC - 1);
    check_regs("glitch");

    apply_raw(8'h2E);
    check_regs("multi");
    drain(3, "multi.event");

    bus_write(ADDR_CONTROL, 32'h8000_FFFF);
    ien_m = 1'b1;
    apply_raw(8'h31);
    check_regs("ovf");
    bus_write(ADDR_STATUS, 32'h0001_0000);
    ovf_m = 1'b0;
    check_regs("w1c");
    drain(FD, "ovf.event");
    check_regs("drained");

    apply_raw(8'h3E);
    check_regs("full");
    c0 = cyc;
    pin = 8'h2E;
    st_m = 8'h2E;
    w = ev(1'b0, 4, c0 + SS + DC);
    tgt = c0 + SS + DC;
    for (int k = 0; k < 100 && cyc < tgt; k++) @(negedge clk);
    if (cyc != tgt) check("pp.align", 32'(cyc), 32'(tgt));
    bus_read(ADDR_EVENT, d);
    check("pp.pop", d, q.pop_front());
    q.push_back(w);
    repeat (HOLD) @(negedge clk);
    check_regs("pushpop");

    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 4) begin
        apply_raw(NCH'($urandom));
      end else if (act < 6) begin
        glitch_raw(NCH'($urandom), $urandom_range(1, DC - 1));
      end else if (act == 6) begin
        d = $urandom;
        d[15:8] = 8'h00;
        d[7:0] = d[7:0] | 8'h0F;
        bus_write(ADDR_CONTROL, d);
        en_m = d[15:0];
        ien_m = d[31];
      end else if (act == 7) begin
        bus_write(ADDR_STATUS, 32'h0001_0000);
        ovf_m = 1'b0;
      end else begin
        drain($urandom_range(1, FD + 1), "rnd.event");
      end
      check_regs("rnd");
    end
    drain(FD + 1, "final.event");

    bus_write(ADDR_CONTROL, 32'h8000_FFFF);
    en_m = 16'hFFFF;
    ien_m = 1'b1;
    apply_raw(~st_m);
    check_regs("prerst");
    rst_n = 1'b0;
    #1;
    check("mid.irq", 32'(irq), 32'h0);
    check("mid.rdata", avs_readdata, 32'h0);
    pin = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_regs("postrst");
    drain(1, "postrst.event");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
